register_slice: RTL

REGISTER_SLICE -- requirements
Module: register_slice

---
 rtl/register_slice_pkg.sv | 13 +
 rtl/register_slice_ctrl.sv | 77 +++++++
 rtl/register_slice.sv | 69 ++++++
 3 files changed

// File: rtl/register_slice_pkg.sv
// Shared state encoding and parameter defaults for the register slice.
package register_slice_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    BUSY  = 2'd1,
    FULL  = 2'd2
  } state_t;

  localparam int DEF_WIDTH       = 32;
  localparam int DEF_STALL_CNT_W = 16;

endpackage

// File: rtl/register_slice_ctrl.sv
// Skid-buffer FSM: tracks occupancy, registers s_ready/m_valid, emits datapath load strobes.
// Flush overrides any transfer in the same cycle and returns to EMPTY.
module register_slice_ctrl
  import register_slice_pkg::*;
(
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_flush,
  input  logic i_s_valid,
  input  logic i_m_ready,
  output logic o_s_ready,
  output logic o_m_valid,
  output logic o_load_main,
  output logic o_load_skid,
  output logic o_main_from_skid
);

  state_t r_state;
  state_t w_state_nxt;
  logic   r_s_ready;
  logic   r_m_valid;
  logic   w_in_xfer;
  logic   w_out_xfer;

  assign w_in_xfer  = i_s_valid & r_s_ready;
  assign w_out_xfer = r_m_valid & i_m_ready;
  assign o_s_ready  = r_s_ready;
  assign o_m_valid  = r_m_valid;

  // Handshake outputs are flopped from the next state so neither depends on the far side combinationally.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state   <= EMPTY;
      r_s_ready <= 1'b0;
      r_m_valid <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_s_ready <= (w_state_nxt != FULL);
      r_m_valid <= (w_state_nxt != EMPTY);
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    if (i_flush) begin
      w_state_nxt = EMPTY;
    end else begin
      case (r_state)
        EMPTY: if (w_in_xfer) w_state_nxt = BUSY;
        BUSY: begin
          if (w_in_xfer && !w_out_xfer)      w_state_nxt = FULL;
          else if (!w_in_xfer && w_out_xfer) w_state_nxt = EMPTY;
        end
        FULL:  if (w_out_xfer) w_state_nxt = BUSY;
        default: w_state_nxt = EMPTY;
      endcase
    end
  end

  always_comb begin
    o_load_main      = 1'b0;
    o_load_skid      = 1'b0;
    o_main_from_skid = 1'b0;
    if (!i_flush) begin
      case (r_state)
        EMPTY: o_load_main = w_in_xfer;
        BUSY: begin
          o_load_main = w_in_xfer & w_out_xfer;
          o_load_skid = w_in_xfer & ~w_out_xfer;
        end
        FULL:  o_main_from_skid = w_out_xfer;
        default: o_load_main = 1'b0;
      endcase
    end
  end

endmodule

// File: rtl/register_slice.sv
// Two-entry skid-buffer register slice, 1-cycle latency, full throughput; s_ready drops only when both entries hold data.
// Optional saturating stall counter enabled by macro REGISTER_SLICE_STALL_CNT_EN (otherwise stall_cnt is tied to 0).
module register_slice
  import register_slice_pkg::*;
#(
  parameter int WIDTH       = DEF_WIDTH,
  parameter int STALL_CNT_W = DEF_STALL_CNT_W
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   flush,
  input  logic                   s_valid,
  output logic                   s_ready,
  input  logic [WIDTH-1:0]       s_data,
  output logic                   m_valid,
  input  logic                   m_ready,
  output logic [WIDTH-1:0]       m_data,
  output logic [STALL_CNT_W-1:0] stall_cnt
);

  logic             w_load_main;
  logic             w_load_skid;
  logic             w_main_from_skid;
  logic             w_m_valid;
  logic [WIDTH-1:0] r_main;
  logic [WIDTH-1:0] r_skid;

  register_slice_ctrl u_ctrl (
    .i_clk            (clk),
    .i_rst_n          (rst_n),
    .i_flush          (flush),
    .i_s_valid        (s_valid),
    .i_m_ready        (m_ready),
    .o_s_ready        (s_ready),
    .o_m_valid        (w_m_valid),
    .o_load_main      (w_load_main),
    .o_load_skid      (w_load_skid),
    .o_main_from_skid (w_main_from_skid)
  );

  // Payload flops carry no reset; validity lives entirely in the controller.
  always_ff @(posedge clk) begin
    if (w_load_main)           r_main <= s_data;
    else if (w_main_from_skid) r_main <= r_skid;
    if (w_load_skid)           r_skid <= s_data;
  end

  assign m_valid = w_m_valid;
  assign m_data  = r_main;

`ifdef REGISTER_SLICE_STALL_CNT_EN
  logic [STALL_CNT_W-1:0] r_stall_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stall_cnt <= '0;
    end else if (flush) begin
      r_stall_cnt <= '0;
    end else if (w_m_valid && !m_ready && (r_stall_cnt != '1)) begin
      r_stall_cnt <= r_stall_cnt + 1'b1;
    end
  end

  assign stall_cnt = r_stall_cnt;
`else
  assign stall_cnt = '0;
`endif

endmodule
